// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_pkg
// Purpose : Shared types and helpers for the LED event blinker.
//           - blink_state_t : 2-bit encoded blink FSM state (IDLE/ON/OFF)
//           - led_lit_level / led_dark_level : pin level for lit/dark LED,
//             derived from the LED_ACTIVE_LOW parameter of the user
//           - clog2_f : ceil(log2(value)) for sizing counters
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package led_blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_t;

  // Pin level that lights the LED.
  function automatic logic led_lit_level(input int active_low);
    return (active_low != 0) ? 1'b0 : 1'b1;
  endfunction

  // Pin level that keeps the LED dark.
  function automatic logic led_dark_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : led_blink_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : led_tick_gen
// Purpose : Free-running TICK_DIV prescaler producing a one-cycle tick.
//           The tick is asserted while count == TICK_DIV-1, after which the
//           count wraps to 0. A synchronous restart forces the count to 0 so
//           the next tick is exactly TICK_DIV cycles after the restart cycle.
// Ports   : clk      in  system clock
//           rst_n    in  reset, asynchronous assert, active-low
//           restart  in  synchronous restart of the prescaler
//           tick     out one-cycle timing tick
// Rev     : 1.0  initial release
// ============================================================================
module led_tick_gen
  import led_blink_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (clog2_f(TICK_DIV) < 1) ? 1 : clog2_f(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_event_blinker.sv
`default_nettype none
// ============================================================================
// Module  : led_event_blinker
// Purpose : Turns single-cycle event pulses into visible LED blinks. Each
//           rising edge of event_i queues one blink in a saturating pending
//           counter; queued blinks play back-to-back with a fixed ON time
//           followed by a fixed OFF time, timed by a local prescaler.
// Ports   : clk_i       in  system clock
//           resetn_i    in  reset, asynchronous, active-low
//           event_i     in  event request; each 0->1 queues one blink
//           clear_i     in  synchronous clear of pending count and overflow
//           led_o       out LED drive (registered)
//           busy_o      out high during ON or OFF phase
//           pending_o   out blinks queued but not yet started
//           overflow_o  out sticky: an event was dropped at saturation
// Rev     : 1.0  initial release
// ============================================================================
module led_event_blinker
  import led_blink_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int ON_TICKS       = 200,
  parameter int OFF_TICKS      = 200,
  parameter int PEND_W         = 4,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              event_i,
  input  logic              clear_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam logic LED_LIT  = led_lit_level(LED_ACTIVE_LOW);
  localparam logic LED_DARK = led_dark_level(LED_ACTIVE_LOW);

  localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_W   = (clog2_f(PH_MAX + 1) < 1) ? 1 : clog2_f(PH_MAX + 1);
  localparam logic [PH_W-1:0]   ON_LOAD  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   OFF_LOAD = PH_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // --------------------------------------------------------------------------
  // Reset synchronizer: asserts asynchronously, releases two clocks after
  // resetn_i rises so every state flop leaves reset on the same edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // --------------------------------------------------------------------------
  // Event edge detect: a level held high queues only one blink.
  // --------------------------------------------------------------------------
  logic ev_q;
  logic rise;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ev_q <= 1'b0;
    end else begin
      ev_q <= event_i;
    end
  end

  assign rise = event_i & ~ev_q;

  // --------------------------------------------------------------------------
  // Blink FSM signals
  // --------------------------------------------------------------------------
  blink_state_t    state_q;
  blink_state_t    state_next;
  logic [PH_W-1:0] phase_cnt;
  logic            tick;
  logic            restart;
  logic            start;
  logic            phase_done;
  logic            led_next;
  logic            busy_next;

  assign start      = (state_q == ST_IDLE) && (pending_o != '0);
  assign phase_done = tick && (phase_cnt == '0);

  // Prescaler stays at 0 throughout IDLE and restarts on each state change,
  // so the first tick of a phase lands exactly TICK_DIV cycles after entry.
  assign restart = (state_q == ST_IDLE) || (state_next != state_q);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk_i),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // --------------------------------------------------------------------------
  // Pending counter. clear_i wins over everything, discarding a coincident
  // rise; the blink already in progress is unaffected.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else if (rise && !start) begin
      if (pending_o == PEND_MAX) begin
        overflow_o <= 1'b1;
      end else begin
        pending_o <= pending_o + 1'b1;
      end
    end else if (start && !rise) begin
      pending_o <= pending_o - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (start)      state_next = ST_ON;
      ST_ON:   if (phase_done) state_next = ST_OFF;
      ST_OFF:  if (phase_done) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output logic, registered from next-state so the pins change on the
  // same edge as the state.
  // --------------------------------------------------------------------------
  always_comb begin
    led_next  = (state_next == ST_ON) ? LED_LIT : LED_DARK;
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      led_o  <= LED_DARK;
      busy_o <= 1'b0;
    end else begin
      led_o  <= led_next;
      busy_o <= busy_next;
    end
  end

  // --------------------------------------------------------------------------
  // Phase tick counter: loaded with (ticks-1) on phase entry and counts down;
  // the tick seen while at 0 ends the phase.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (state_next != state_q) begin
      case (state_next)
        ST_ON:   phase_cnt <= ON_LOAD;
        ST_OFF:  phase_cnt <= OFF_LOAD;
        default: phase_cnt <= '0;
      endcase
    end else if (tick && (phase_cnt != '0)) begin
      phase_cnt <= phase_cnt - 1'b1;
    end
  end

endmodule : led_event_blinker
`default_nettype wire

// File: tb/tb_led_event_blinker.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_event_blinker
// Purpose : Directed self-checking bench for led_event_blinker with
//           TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2, PEND_W=2, active-high LED.
//           Cycle n is the interval after the n-th clock edge counted from
//           each scenario origin; a blink period is 12 ON + 8 OFF + 1 IDLE.
// Rev     : 1.0  initial release
// ============================================================================
module tb_led_event_blinker;

  logic       clk;
  logic       resetn;
  logic       event_in;
  logic       clear;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int cyc;
  int checks;
  int errors;

  led_event_blinker #(
    .TICK_DIV       (4),
    .ON_TICKS       (3),
    .OFF_TICKS      (2),
    .PEND_W         (2),
    .LED_ACTIVE_LOW (0)
  ) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .event_i    (event_in),
    .clear_i    (clear),
    .led_o      (led),
    .busy_o     (busy),
    .pending_o  (pending),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  // Full reset, then origin cycle 0 with the internal reset already released.
  task automatic start_test();
    event_in = 1'b0;
    clear    = 1'b0;
    resetn   = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    step();
    step();
    cyc = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (led !== 1'b0 || busy !== 1'b0 || pending !== 2'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got led=%b busy=%b pend=%0d ovf=%b exp 0/0/0/0", led, busy, pending, overflow);
    end
    step();
    step();
    checks++;
    if (led !== 1'b0 || busy !== 1'b0 || pending !== 2'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got led=%b busy=%b pend=%0d ovf=%b exp 0/0/0/0", led, busy, pending, overflow);
    end
  endtask

  task automatic test_single();
    logic exp_led, exp_busy;
    start_test();
    for (int c = 1; c <= 34; c++) begin
      goto(c);
      if (c == 11) begin
        checks++;
        if (pending !== 2'd1) begin
          errors++;
          $display("FAIL single_pend11 got %0d exp 1", pending);
        end
      end
      if (c >= 11) begin
        exp_led  = (c >= 12 && c <= 23);
        exp_busy = (c >= 12 && c <= 31);
        checks++;
        if (led !== exp_led || busy !== exp_busy) begin
          errors++;
          $display("FAIL single_led_busy c=%0d got led=%b busy=%b exp led=%b busy=%b", c, led, busy, exp_led, exp_busy);
        end
      end
      if (c >= 12) begin
        checks++;
        if (pending !== 2'd0) begin
          errors++;
          $display("FAIL single_pend0 c=%0d got %0d exp 0", c, pending);
        end
      end
      event_in = (c == 10);
    end
  endtask

  task automatic test_back_to_back();
    logic prev;
    int   nr;
    int   r[4];
    start_test();
    prev = 1'b0;
    nr   = 0;
    for (int c = 1; c <= 80; c++) begin
      goto(c);
      if (led && !prev) begin
        if (nr < 4) r[nr] = c;
        nr++;
      end
      prev = led;
      if (c == 15 || c == 19 || c == 33 || c == 54) begin
        checks++;
        if (pending !== ((c == 19) ? 2'd2 : (c == 54) ? 2'd0 : 2'd1)) begin
          errors++;
          $display("FAIL b2b_pending c=%0d got %0d", c, pending);
        end
      end
      event_in = (c == 10 || c == 14 || c == 18);
    end
    checks++;
    if (nr !== 3 || r[0] !== 12 || r[1] !== 33 || r[2] !== 54) begin
      errors++;
      $display("FAIL b2b_starts got n=%0d at %0d,%0d,%0d exp 3 at 12,33,54", nr, r[0], r[1], r[2]);
    end
  endtask

  task automatic test_saturation();
    logic prev;
    int   nr;
    int   last;
    start_test();
    prev = 1'b0;
    nr   = 0;
    last = 0;
    for (int c = 1; c <= 120; c++) begin
      goto(c);
      if (led && !prev) begin
        nr++;
        last = c;
      end
      prev = led;
      if (c == 19 || c == 21 || c == 23) begin
        checks++;
        if (pending !== 2'd3) begin
          errors++;
          $display("FAIL sat_pending c=%0d got %0d exp 3", c, pending);
        end
      end
      if (c == 20 || c == 21 || c == 60 || c == 120) begin
        checks++;
        if (overflow !== (c != 20)) begin
          errors++;
          $display("FAIL sat_overflow c=%0d got %b exp %b", c, overflow, (c != 20));
        end
      end
      event_in = (c == 10 || c == 14 || c == 16 || c == 18 || c == 20 || c == 22);
    end
    checks++;
    if (nr !== 4 || last !== 75) begin
      errors++;
      $display("FAIL sat_blinks got n=%0d last=%0d exp 4 last=75", nr, last);
    end
  endtask

  task automatic test_level_hold();
    logic prev;
    int   nr;
    start_test();
    prev = 1'b0;
    nr   = 0;
    for (int c = 1; c <= 70; c++) begin
      goto(c);
      if (led && !prev) nr++;
      prev = led;
      if (c == 11 || c == 20 || c == 40) begin
        checks++;
        if (pending !== ((c == 11) ? 2'd1 : 2'd0)) begin
          errors++;
          $display("FAIL level_pending c=%0d got %0d", c, pending);
        end
      end
      event_in = (c >= 10 && c <= 40);
    end
    checks++;
    if (nr !== 1 || busy !== 1'b0 || pending !== 2'd0) begin
      errors++;
      $display("FAIL level_once got n=%0d busy=%b pend=%0d exp 1/0/0", nr, busy, pending);
    end
  endtask

  task automatic test_coincident();
    logic prev;
    int   nr;
    int   r[4];
    start_test();
    prev = 1'b0;
    nr   = 0;
    for (int c = 1; c <= 80; c++) begin
      goto(c);
      if (led && !prev) begin
        if (nr < 4) r[nr] = c;
        nr++;
      end
      prev = led;
      if (c == 15 || c == 32 || c == 33 || c == 54) begin
        checks++;
        if (pending !== ((c == 54) ? 2'd0 : 2'd1)) begin
          errors++;
          $display("FAIL coinc_pending c=%0d got %0d", c, pending);
        end
      end
      event_in = (c == 10 || c == 14 || c == 32);
    end
    checks++;
    if (nr !== 3 || r[0] !== 12 || r[1] !== 33 || r[2] !== 54) begin
      errors++;
      $display("FAIL coinc_starts got n=%0d at %0d,%0d,%0d exp 3 at 12,33,54", nr, r[0], r[1], r[2]);
    end
  endtask

  task automatic test_clear();
    logic prev;
    int   nr;
    start_test();
    prev = 1'b0;
    nr   = 0;
    for (int c = 1; c <= 80; c++) begin
      goto(c);
      if (led && !prev) nr++;
      prev = led;
      if (c == 22) begin
        checks++;
        if (pending !== 2'd3 || overflow !== 1'b1) begin
          errors++;
          $display("FAIL clear_pre got pend=%0d ovf=%b exp 3/1", pending, overflow);
        end
      end
      if (c == 23) begin
        checks++;
        if (pending !== 2'd0 || overflow !== 1'b0 || led !== 1'b1) begin
          errors++;
          $display("FAIL clear_post got pend=%0d ovf=%b led=%b exp 0/0/1", pending, overflow, led);
        end
      end
      if (c == 24 || c == 31 || c == 32) begin
        checks++;
        if (led !== 1'b0 || busy !== (c != 32)) begin
          errors++;
          $display("FAIL clear_finish c=%0d got led=%b busy=%b exp 0/%b", c, led, busy, (c != 32));
        end
      end
      event_in = (c == 10 || c == 14 || c == 16 || c == 18 || c == 20 || c == 22);
      clear    = (c == 22);
    end
    checks++;
    if (nr !== 1 || pending !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_nomore got n=%0d pend=%0d busy=%b exp 1/0/0", nr, pending, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_led;
    start_test();
    for (int c = 1; c <= 15; c++) begin
      goto(c);
      event_in = (c == 10 || c == 13);
    end
    checks++;
    if (led !== 1'b1 || pending !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_pre got led=%b pend=%0d exp 1/1", led, pending);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (led !== 1'b0 || busy !== 1'b0 || pending !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async got led=%b busy=%b pend=%0d exp 0/0/0", led, busy, pending);
    end
    step();
    step();
    resetn = 1'b1;
    cyc = 0;
    // A pulse while the synchronized reset is still asserted is ignored.
    for (int c = 1; c <= 24; c++) begin
      goto(c);
      if (c == 2 || c == 3 || c == 12) begin
        checks++;
        if (pending !== 2'd0 || busy !== (c == 12)) begin
          errors++;
          $display("FAIL rstmid_release c=%0d got pend=%0d busy=%b", c, pending, busy);
        end
      end
      if (c == 11) begin
        checks++;
        if (pending !== 2'd1) begin
          errors++;
          $display("FAIL rstmid_pend11 got %0d exp 1", pending);
        end
      end
      if (c >= 11) begin
        exp_led = (c >= 12 && c <= 23);
        checks++;
        if (led !== exp_led) begin
          errors++;
          $display("FAIL rstmid_led c=%0d got %b exp %b", c, led, exp_led);
        end
      end
      event_in = (c == 1 || c == 10);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    event_in = 1'b0;
    clear    = 1'b0;
    resetn   = 1'b1;
    #2;
    resetn = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_level_hold();
    test_coincident();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got time=%0t exp completion", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_led_event_blinker
`default_nettype wire
